// File: rtl/io_serial_tx.sv
// io_serial_tx: CPU-written byte FIFO feeding an asynchronous serial transmitter (start, 8 data LSB first, stop).
// Build option: define IO_SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module io_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [7:0]    wd,
    input  logic          clr_ovf,
    output logic          tx,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef IO_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef IO_SERIAL_TX_PARITY_EN
    logic          par_q;
`endif

    logic       push;
    logic       pop;
    logic       baud_done;
    logic [7:0] head;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign head      = mem_q[rd_ptr_q];
    assign baud_done = (baud_q == BAUD_LAST);
    assign push      = we && !full;
    // Pops only leave IDLE or the last STOP cycle, so the next start bit follows with no gap.
    assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
            // A dropped write outranks a simultaneous clear.
            if (we && full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef IO_SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q <= S_START;
                        baud_q  <= '0;
                        shift_q <= head;
                        tx_q    <= 1'b0;
`ifdef IO_SERIAL_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state_q <= S_DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef IO_SERIAL_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef IO_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        state_q <= S_STOP;
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            state_q <= S_START;
                            shift_q <= head;
                            tx_q    <= 1'b0;
`ifdef IO_SERIAL_TX_PARITY_EN
                            par_q   <= ^head;
`endif
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_serial_tx.sv
// Directed bench for io_serial_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a background UART model decodes tx.
// Parity scenario is compiled in when IO_SERIAL_TX_PARITY_EN is defined.
module tb_io_serial_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IO_SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    wd = 8'h00;
    logic          clr_ovf = 1'b0;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;

    int         n_checks = 0;
    int         n_pass = 0;
    int         rx_err = 0;
    logic       mon_en = 1'b0;
    logic       rx_ok;
    logic [7:0] rx_b;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    io_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .we(we), .wd(wd), .clr_ovf(clr_ovf),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count), .ovf(ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Receiver model: detect start at negedge, sample each bit at its middle.
    always begin
        @(negedge clk);
        if (mon_en && !reset && tx === 1'b0) begin
            rx_ok = 1'b1;
            rx_b  = 8'h00;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) rx_ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                rx_b[k] = tx;
            end
`ifdef IO_SERIAL_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            if (tx !== ^rx_b) rx_ok = 1'b0;
`endif
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) rx_ok = 1'b0;
            if (mon_en) begin
                if (rx_ok) got_q.push_back(rx_b);
                else rx_err++;
            end
        end
    end

    // Expected line level i cycles after the start bit begins.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int s;
        s = i / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
`ifdef IO_SERIAL_TX_PARITY_EN
        if (s == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // driver tasks
    task automatic write_byte(input logic [7:0] b);
        wd = b;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!busy && empty) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
        n_checks++; if (count !== CW'(0)) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        n_checks++; if (count !== CW'(1)) $display("FAIL single_count_e1 got %0d exp 1", count); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_e1 got %b exp 1", tx); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else n_pass++;
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (tx !== exp_bit(8'hA5, i)) $display("FAIL single_tx[%0d] got %b exp %b", i, tx, exp_bit(8'hA5, i));
            else n_pass++;
            n_checks++; if (empty !== 1'b1) $display("FAIL single_empty[%0d] got %b exp 1", i, empty); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy); else n_pass++;
        n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_end got %b exp 1", tx); else n_pass++;
        wait_idle(ok);
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL single_rx_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) $display("FAIL single_rx[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        wd = 8'h01; we = 1'b1;
        @(negedge clk);
        n_checks++; if (count !== CW'(1)) $display("FAIL b2b_count_e1 got %0d exp 1", count); else n_pass++;
        wd = 8'h80;
        @(negedge clk);
        we = 1'b0;
        n_checks++; if (count !== CW'(1)) $display("FAIL b2b_count_e2 got %0d exp 1", count); else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            e = (i < FRAME) ? exp_bit(8'h01, i) : exp_bit(8'h80, i - FRAME);
            n_checks++; if (tx !== e) $display("FAIL b2b_tx[%0d] got %b exp %b", i, tx, e); else n_pass++;
            if (i == FRAME) begin
                n_checks++; if (count !== CW'(0)) $display("FAIL b2b_count_pop2 got %0d exp 0", count); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_gap got %b exp 1", busy); else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b exp 0", busy); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_rx_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) $display("FAIL b2b_rx[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h10 + 8'(k));
        for (int k = 0; k < 6; k++) begin
            wd = 8'h10 + 8'(k);
            we = 1'b1;
            clr_ovf = (k == 5);   // dropped write and clear on the same edge
            @(negedge clk);
            if (k == 4) begin
                n_checks++; if (count !== CW'(4)) $display("FAIL ovf_count4 got %0d exp 4", count); else n_pass++;
                n_checks++; if (full !== 1'b1) $display("FAIL ovf_full got %b exp 1", full); else n_pass++;
                n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_early got %b exp 0", ovf); else n_pass++;
            end
        end
        we = 1'b0;
        clr_ovf = 1'b0;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", ovf); else n_pass++;
        n_checks++; if (count !== CW'(4)) $display("FAIL ovf_count_drop got %0d exp 4", count); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else n_pass++;
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b exp 0", ovf); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL ovf_idle_timeout got busy %b exp 0", busy); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL ovf_rx_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) $display("FAIL ovf_rx[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        mon_en = 1'b0;
        wd = 8'h20; we = 1'b1;
        @(negedge clk);
        wd = 8'h21;
        @(negedge clk);
        wd = 8'h22;
        @(negedge clk);
        we = 1'b0;
        repeat (16) @(negedge clk);   // 17 cycles into the frame: DATA bit 3
        n_checks++; if (count !== CW'(2)) $display("FAIL rmid_count_pre got %0d exp 2", count); else n_pass++;
        n_checks++; if (tx !== 1'b0) $display("FAIL rmid_tx_pre got %b exp 0", tx); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL rmid_tx got %b exp 1", tx); else n_pass++;
        n_checks++; if (count !== CW'(0)) $display("FAIL rmid_count got %0d exp 0", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rmid_empty got %b exp 1", empty); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (!quiet) $display("FAIL rmid_quiet got activity exp idle tx=%b busy=%b", tx, busy); else n_pass++;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'h5A);
        mon_en = 1'b1;
        write_byte(8'h5A);
        @(negedge clk);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL rmid_idle_timeout got busy %b exp 0", busy); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rmid_rx_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) $display("FAIL rmid_rx[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(8'(k));
            ok = 1'b0;
            for (int t = 0; t < 3000; t++) begin
                if (!full) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            n_checks++; if (!ok) $display("FAIL wrap_full_timeout[%0d] got full %b exp 0", k, full); else n_pass++;
            write_byte(8'(k));
        end
        @(negedge clk);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL wrap_idle_timeout got busy %b exp 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL wrap_ovf got %b exp 0", ovf); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL wrap_rx_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_checks++; if (got_q[k] !== exp_q[k]) $display("FAIL wrap_rx[%0d] got %h exp %h", k, got_q[k], exp_q[k]); else n_pass++;
        end
    endtask

`ifdef IO_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       pbit;
        for (int n = 0; n < 2; n++) begin
            b    = (n == 0) ? 8'h07 : 8'h03;
            pbit = (n == 0) ? 1'b1 : 1'b0;
            write_byte(b);
            @(negedge clk);
            for (int i = 0; i < FRAME; i++) begin
                if (i == 9 * CPB + 1) begin
                    n_checks++; if (tx !== pbit) $display("FAIL par_bit_%h got %b exp %b", b, tx, pbit); else n_pass++;
                end
                if (i == FRAME - 1) begin
                    n_checks++; if (busy !== 1'b1) $display("FAIL par_busy_last_%h got %b exp 1", b, busy); else n_pass++;
                end
                n_checks++; if (tx !== exp_bit(b, i)) $display("FAIL par_tx_%h[%0d] got %b exp %b", b, i, tx, exp_bit(b, i)); else n_pass++;
                @(negedge clk);
            end
            n_checks++; if (busy !== 1'b0) $display("FAIL par_len_%h got busy %b exp 0", b, busy); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
`ifdef IO_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        repeat (4) @(negedge clk);
        n_checks++; if (rx_err != 0) $display("FAIL rx_frame_errors got %0d exp 0", rx_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
